calc1_port_driver: RTL and testbench
====================================

CALC1_PORT_DRIVER -- requirements
Module: calc1_port_driver

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning max WAIT cycles before abandoning a response (legal 1..255).
REQ-002 SHALL have c_clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have op_valid  input  1  host presents an operation.
REQ-005 SHALL have op_ready  output  1  driver can accept an operation.
REQ-006 SHALL have op_cmd  input  [0:3]  calc1 command (bit 0 MSB).
REQ-007 SHALL have op_a, op_b  input  [0:31] each  operand 1 and operand 2.
REQ-008 SHALL have req_cmd_out  output  [0:3]  command to calc1 port.
REQ-009 SHALL have req_data_out  output  [0:31]  data to calc1 port.
REQ-010 SHALL have out_resp  input  [0:1]  calc1 port response (0 none, 1 success, 2 overflow/underflow/invalid, 3 reserved).
REQ-011 SHALL have out_data  input  [0:31]  calc1 port result.
REQ-012 SHALL have res_valid  output  1  one-cycle result strobe.
REQ-013 SHALL have res_resp, res_data  output  [0:1], [0:31]  captured response and result.
REQ-014 SHALL have res_timeout  output  1  result ended by timeout.
REQ-015 SHALL have spurious_resp  output  1  sticky: nonzero out_resp seen outside WAIT.

Function
REQ-016 SHALL implement states IDLE, SEND1, SEND2, WAIT, DONE; all outputs registered.
REQ-017 op_ready SHALL be 1 only in IDLE; accept = op_valid && op_ready at cycle T, latching op_cmd/op_a/op_b.
REQ-018 Accepted op_cmd != 0 SHALL go IDLE->SEND1; op_cmd == 0 SHALL go IDLE->DONE with res_resp=2, res_data=0, res_timeout=0, no port activity.
REQ-019 SEND1 (cycle T+1): req_cmd_out=op_cmd, req_data_out=op_a; then SEND2.
REQ-020 SEND2 (cycle T+2): req_cmd_out=0, req_data_out=op_b; then WAIT with wait counter cleared.
REQ-021 Outside SEND1/SEND2, req_cmd_out and req_data_out SHALL be 0.
REQ-022 WAIT: out_resp sampled each cycle; nonzero -> capture out_resp/out_data, go DONE; counter increments otherwise (8-bit).
REQ-023 If no response by the TIMEOUT-th WAIT cycle, SHALL go DONE with res_timeout=1, res_resp=0, res_data=0.
REQ-024 Response arriving on WAIT cycle R SHALL give res_valid=1 at cycle R+1 (DONE), for exactly one cycle.
REQ-025 res_resp/res_data/res_timeout SHALL hold their last captured values until next DONE; DONE->IDLE unconditionally.
REQ-026 Nonzero out_resp in IDLE, SEND1, SEND2 or DONE SHALL be ignored for results and SHALL set spurious_resp, which stays 1 until reset.
REQ-027 Response on the same cycle the timeout fires SHALL be treated as a response (res_timeout=0).
REQ-028 Operands SHALL be forwarded unmodified; no arithmetic or command validation beyond cmd==0.

Reset
REQ-029 reset==0 at a rising edge SHALL force IDLE, counter 0, and all outputs 0 (incl. op_ready, spurious_resp).
REQ-030 op_ready SHALL be 1 the first cycle after reset returns to 1.
REQ-031 Reset mid-operation SHALL abandon it: no res_valid, port outputs 0 next cycle.

Verification
REQ-032 add: op_cmd=1, a=5, b=3; model returns resp=1, data=8 on 4th WAIT cycle -> SEND1 cmd=1/data=5, SEND2 cmd=0/data=3, res_valid one cycle later with res_resp=1, res_data=8.
REQ-033 overflow: op_cmd=1, a=FFFFFFFF, b=1; model returns resp=2 -> res_resp=2, res_timeout=0.
REQ-034 timeout: TIMEOUT=4, no response -> res_valid on cycle after 4th WAIT cycle, res_timeout=1, res_resp=0, res_data=0.
REQ-035 cmd 0: op_cmd=0 accepted at T -> req_cmd_out stays 0, res_valid at T+1 with res_resp=2, op_ready at T+2.
REQ-036 reset low during WAIT -> no res_valid, all outputs 0, op_ready=1 cycle after reset release.
REQ-037 out_resp=1 driven while IDLE -> spurious_resp=1 and held through later transactions until reset; res_valid stays 0.

Source files
------------

// File: rtl/calc1_port_driver.sv
// Drives one calc1 port: sends a two-beat request, waits for a response or a
// timeout, and reports a one-cycle result strobe with the captured response.
module calc1_port_driver #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [0:3]  op_cmd,
  input  logic [0:31] op_a,
  input  logic [0:31] op_b,
  output logic [0:3]  req_cmd_out,
  output logic [0:31] req_data_out,
  input  logic [0:1]  out_resp,
  input  logic [0:31] out_data,
  output logic        res_valid,
  output logic [0:1]  res_resp,
  output logic [0:31] res_data,
  output logic        res_timeout,
  output logic        spurious_resp
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND1,
    S_SEND2,
    S_WAIT,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [0:31]      b_q, b_d;
  logic             op_ready_q, op_ready_d;
  logic [0:3]       req_cmd_q, req_cmd_d;
  logic [0:31]      req_data_q, req_data_d;
  logic             res_valid_q, res_valid_d;
  logic [0:1]       res_resp_q, res_resp_d;
  logic [0:31]      res_data_q, res_data_d;
  logic             res_timeout_q, res_timeout_d;
  logic             spurious_q, spurious_d;

  // Outputs are derived from the next state so they line up with it once registered.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    b_d           = b_q;
    req_cmd_d     = '0;
    req_data_d    = '0;
    res_resp_d    = res_resp_q;
    res_data_d    = res_data_q;
    res_timeout_d = res_timeout_q;
    spurious_d    = spurious_q | ((state_q != S_WAIT) && (out_resp != 2'b00));

    case (state_q)
      S_IDLE: begin
        if (op_valid && op_ready_q) begin
          b_d = op_b;
          if (op_cmd != 4'b0000) begin
            state_d    = S_SEND1;
            req_cmd_d  = op_cmd;
            req_data_d = op_a;
          end else begin
            state_d       = S_DONE;
            res_resp_d    = 2'd2;
            res_data_d    = '0;
            res_timeout_d = 1'b0;
          end
        end
      end
      S_SEND1: begin
        state_d    = S_SEND2;
        req_data_d = b_q;
      end
      S_SEND2: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        // A response on the final wait cycle wins over the timeout.
        if (out_resp != 2'b00) begin
          state_d       = S_DONE;
          res_resp_d    = out_resp;
          res_data_d    = out_data;
          res_timeout_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d       = S_DONE;
          res_resp_d    = '0;
          res_data_d    = '0;
          res_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    op_ready_d  = (state_d == S_IDLE);
    res_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge c_clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      b_q           <= '0;
      op_ready_q    <= 1'b0;
      req_cmd_q     <= '0;
      req_data_q    <= '0;
      res_valid_q   <= 1'b0;
      res_resp_q    <= '0;
      res_data_q    <= '0;
      res_timeout_q <= 1'b0;
      spurious_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      b_q           <= b_d;
      op_ready_q    <= op_ready_d;
      req_cmd_q     <= req_cmd_d;
      req_data_q    <= req_data_d;
      res_valid_q   <= res_valid_d;
      res_resp_q    <= res_resp_d;
      res_data_q    <= res_data_d;
      res_timeout_q <= res_timeout_d;
      spurious_q    <= spurious_d;
    end
  end

  assign op_ready      = op_ready_q;
  assign req_cmd_out   = req_cmd_q;
  assign req_data_out  = req_data_q;
  assign res_valid     = res_valid_q;
  assign res_resp      = res_resp_q;
  assign res_data      = res_data_q;
  assign res_timeout   = res_timeout_q;
  assign spurious_resp = spurious_q;

endmodule

// File: tb/tb_calc1_port_driver.sv
// Directed bench for calc1_port_driver: expected results are queued when an
// operation is issued and compared when res_valid appears.
module tb_calc1_port_driver;

  logic        c_clk;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [0:3]  op_cmd;
  logic [0:31] op_a;
  logic [0:31] op_b;
  logic [0:3]  req_cmd_out;
  logic [0:31] req_data_out;
  logic [0:1]  out_resp;
  logic [0:31] out_data;
  logic        res_valid;
  logic [0:1]  res_resp;
  logic [0:31] res_data;
  logic        res_timeout;
  logic        spurious_resp;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
    logic        tmo;
  } exp_t;

  exp_t sb[$];

  calc1_port_driver #(.TIMEOUT(4)) dut (
    .c_clk        (c_clk),
    .reset        (reset),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_cmd       (op_cmd),
    .op_a         (op_a),
    .op_b         (op_b),
    .req_cmd_out  (req_cmd_out),
    .req_data_out (req_data_out),
    .out_resp     (out_resp),
    .out_data     (out_data),
    .res_valid    (res_valid),
    .res_resp     (res_resp),
    .res_data     (res_data),
    .res_timeout  (res_timeout),
    .spurious_resp(spurious_resp)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge c_clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1;
    op_cmd   = cmd;
    op_a     = a;
    op_b     = b;
  endtask

  // Scoreboard consumer: every res_valid pulse must match the oldest queued result.
  always @(posedge c_clk) begin
    #1;
    if (res_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_res_valid", 32'(res_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_resp", 32'(res_resp), 32'(e.resp));
        chk("sb_data", 32'(res_data), e.data);
        chk("sb_timeout", 32'(res_timeout), 32'(e.tmo));
      end
    end
  end

  initial begin
    reset    = 1'b0;
    op_valid = 1'b0;
    op_cmd   = '0;
    op_a     = '0;
    op_b     = '0;
    out_resp = '0;
    out_data = '0;
    tick;
    tick;
    chk("rst_op_ready", 32'(op_ready), 32'd0);
    chk("rst_req_cmd", 32'(req_cmd_out), 32'd0);
    chk("rst_req_data", 32'(req_data_out), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_spurious", 32'(spurious_resp), 32'd0);
    reset = 1'b1;
    tick;
    chk("post_rst_op_ready", 32'(op_ready), 32'd1);

    // add 5+3, response on the 4th wait cycle (same cycle as timeout)
    issue(4'd1, 32'd5, 32'd3);
    sb.push_back('{resp: 2'd1, data: 32'd8, tmo: 1'b0});
    tick;
    op_valid = 1'b0;
    chk("add_send1_cmd", 32'(req_cmd_out), 32'd1);
    chk("add_send1_data", 32'(req_data_out), 32'd5);
    chk("add_send1_ready", 32'(op_ready), 32'd0);
    tick;
    chk("add_send2_cmd", 32'(req_cmd_out), 32'd0);
    chk("add_send2_data", 32'(req_data_out), 32'd3);
    tick;
    chk("add_wait_data", 32'(req_data_out), 32'd0);
    tick;
    tick;
    tick;
    chk("add_wait4_valid", 32'(res_valid), 32'd0);
    out_resp = 2'd1;
    out_data = 32'd8;
    tick;
    out_resp = 2'd0;
    out_data = 32'd0;
    chk("add_done_valid", 32'(res_valid), 32'd1);
    tick;
    chk("add_idle_valid", 32'(res_valid), 32'd0);
    chk("add_idle_ready", 32'(op_ready), 32'd1);
    chk("add_hold_resp", 32'(res_resp), 32'd1);
    chk("add_hold_data", 32'(res_data), 32'd8);

    // overflow, response resp=2 on the 2nd wait cycle
    issue(4'd1, 32'hFFFF_FFFF, 32'd1);
    sb.push_back('{resp: 2'd2, data: 32'h1234_0000, tmo: 1'b0});
    tick;
    op_valid = 1'b0;
    chk("ovf_send1_data", 32'(req_data_out), 32'hFFFF_FFFF);
    tick;
    chk("ovf_send2_data", 32'(req_data_out), 32'd1);
    tick;
    tick;
    out_resp = 2'd2;
    out_data = 32'h1234_0000;
    tick;
    out_resp = 2'd0;
    out_data = 32'd0;
    chk("ovf_done_valid", 32'(res_valid), 32'd1);
    tick;

    // timeout: no response for 4 wait cycles
    issue(4'd3, 32'd7, 32'd9);
    sb.push_back('{resp: 2'd0, data: 32'd0, tmo: 1'b1});
    tick;
    op_valid = 1'b0;
    chk("tmo_send1_cmd", 32'(req_cmd_out), 32'd3);
    tick;
    tick;
    tick;
    tick;
    tick;
    chk("tmo_wait4_valid", 32'(res_valid), 32'd0);
    tick;
    chk("tmo_done_valid", 32'(res_valid), 32'd1);
    chk("tmo_flag", 32'(res_timeout), 32'd1);
    tick;
    chk("tmo_hold_flag", 32'(res_timeout), 32'd1);

    // cmd 0: immediate DONE with resp=2 and no port activity
    issue(4'd0, 32'd55, 32'd66);
    sb.push_back('{resp: 2'd2, data: 32'd0, tmo: 1'b0});
    tick;
    op_valid = 1'b0;
    chk("cmd0_req_cmd", 32'(req_cmd_out), 32'd0);
    chk("cmd0_req_data", 32'(req_data_out), 32'd0);
    chk("cmd0_valid", 32'(res_valid), 32'd1);
    tick;
    chk("cmd0_ready", 32'(op_ready), 32'd1);

    // reset during WAIT abandons the operation
    issue(4'd2, 32'd1, 32'd2);
    tick;
    op_valid = 1'b0;
    tick;
    tick;
    reset = 1'b0;
    tick;
    chk("midrst_ready", 32'(op_ready), 32'd0);
    chk("midrst_req_cmd", 32'(req_cmd_out), 32'd0);
    chk("midrst_req_data", 32'(req_data_out), 32'd0);
    chk("midrst_valid", 32'(res_valid), 32'd0);
    chk("midrst_resp", 32'(res_resp), 32'd0);
    chk("midrst_tmo", 32'(res_timeout), 32'd0);
    reset = 1'b1;
    tick;
    chk("midrst_release_ready", 32'(op_ready), 32'd1);
    tick;
    chk("midrst_no_valid", 32'(res_valid), 32'd0);

    // spurious response while IDLE, then a normal transaction
    out_resp = 2'd1;
    out_data = 32'd99;
    tick;
    out_resp = 2'd0;
    out_data = 32'd0;
    chk("spur_set", 32'(spurious_resp), 32'd1);
    chk("spur_no_valid", 32'(res_valid), 32'd0);
    issue(4'd4, 32'd10, 32'd20);
    sb.push_back('{resp: 2'd1, data: 32'd30, tmo: 1'b0});
    tick;
    op_valid = 1'b0;
    tick;
    tick;
    out_resp = 2'd1;
    out_data = 32'd30;
    tick;
    out_resp = 2'd0;
    out_data = 32'd0;
    chk("spur_txn_valid", 32'(res_valid), 32'd1);
    chk("spur_held", 32'(spurious_resp), 32'd1);
    tick;
    reset = 1'b0;
    tick;
    chk("spur_cleared", 32'(spurious_resp), 32'd0);
    reset = 1'b1;
    tick;
    tick;
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
